// File: rtl/obi_master_arbiter.sv
// Shares one OBI master port between NUM_REQ requesters with round-robin selection and in-order response routing.
// Define OBI_ARB_FIXED_PRIO_EN for fixed priority, where the lowest-index requester wins.
module obi_master_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int OBI_ADDR_WIDTH  = 32,
  parameter int OBI_DATA_WIDTH  = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                obi_aclk,
  input  logic                                obi_areset,
  input  logic [NUM_REQ-1:0]                  req_req,
  output logic [NUM_REQ-1:0]                  req_gnt,
  input  logic [NUM_REQ*OBI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]                  req_we,
  input  logic [NUM_REQ*OBI_DATA_WIDTH-1:0]   req_w_data,
  output logic [NUM_REQ-1:0]                  req_r_valid,
  input  logic [NUM_REQ-1:0]                  req_r_ready,
  output logic [OBI_DATA_WIDTH-1:0]           req_r_data,
  output logic                                obi_master_req,
  input  logic                                obi_master_gnt,
  output logic [OBI_ADDR_WIDTH-1:0]           obi_master_addr,
  output logic                                obi_master_we,
  output logic [OBI_DATA_WIDTH-1:0]           obi_master_w_data,
  input  logic                                obi_master_r_valid,
  output logic                                obi_master_r_ready,
  input  logic [OBI_DATA_WIDTH-1:0]           obi_master_r_data,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                spurious_rsp,
  output logic                                dbg_state_o
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = $clog2(MAX_OUTSTANDING);
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

  // Handshakes: a request transfers on obi_master_req && obi_master_gnt; a response transfers on
  // obi_master_r_valid && obi_master_r_ready. Selection stays locked from request until grant.
  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t           state_q;
  logic [IDW-1:0]   lock_id_q;
  logic [IDW-1:0]   fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             spurious_q;

  logic [OBI_ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [OBI_DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  logic [IDW-1:0] winner, cand, sel_id, head;
  logic           found, full, empty, m_req, gnt_fire, push, pop;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign addr_arr[g]  = req_addr[g*OBI_ADDR_WIDTH +: OBI_ADDR_WIDTH];
    assign wdata_arr[g] = req_w_data[g*OBI_DATA_WIDTH +: OBI_DATA_WIDTH];
  end

`ifdef OBI_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDW'(i);
      if (!found && req_req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end
`else
  logic [IDW-1:0] rr_ptr_q;

  // Circular search for the first active requester at or after rr_ptr_q.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && req_req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end
`endif

  assign full     = (cnt_q == CW'(MAX_OUTSTANDING));
  assign empty    = (cnt_q == '0);
  assign sel_id   = (state_q == S_LOCKED) ? lock_id_q : winner;
  // A lock is only taken while the FIFO has room, so a locked request ignores the full flag.
  assign m_req    = (state_q == S_LOCKED) ? req_req[lock_id_q] : (found && !full);
  assign gnt_fire = m_req && obi_master_gnt;
  assign push     = gnt_fire;

  assign obi_master_req    = m_req;
  assign obi_master_addr   = addr_arr[sel_id];
  assign obi_master_we     = req_we[sel_id];
  assign obi_master_w_data = wdata_arr[sel_id];
  assign req_gnt           = gnt_fire ? (NUM_REQ'(1) << sel_id) : '0;

  assign head               = fifo_q[rd_ptr_q];
  assign obi_master_r_ready = empty ? 1'b1 : req_r_ready[head];
  assign req_r_valid        = (!empty && obi_master_r_valid) ? (NUM_REQ'(1) << head) : '0;
  assign req_r_data         = obi_master_r_data;
  assign pop                = obi_master_r_valid && obi_master_r_ready && !empty;

  assign cnt_d        = cnt_q + CW'(push) - CW'(pop);
  assign outstanding  = cnt_q;
  assign spurious_rsp = spurious_q;
  assign dbg_state_o  = (state_q == S_LOCKED);

  always_ff @(posedge obi_aclk) begin
    if (obi_areset) begin
      state_q   <= S_IDLE;
      lock_id_q <= '0;
`ifndef OBI_ARB_FIXED_PRIO_EN
      rr_ptr_q  <= '0;
`endif
    end else begin
`ifndef OBI_ARB_FIXED_PRIO_EN
      if (gnt_fire) rr_ptr_q <= (sel_id == IDW'(NUM_REQ - 1)) ? '0 : sel_id + 1'b1;
`endif
      case (state_q)
        S_IDLE: begin
          if (m_req && !obi_master_gnt) begin
            lock_id_q <= winner;
            state_q   <= S_LOCKED;
          end
        end
        S_LOCKED: begin
          // Dropping the request before grant abandons the lock without a push.
          if (gnt_fire || !req_req[lock_id_q]) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge obi_aclk) begin
    if (obi_areset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      spurious_q <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= sel_id;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
      if (obi_master_r_valid && empty) spurious_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_obi_master_arbiter.sv
// Directed bench for obi_master_arbiter: a queue-based model checked every cycle plus literal expectations.
module tb_obi_master_arbiter;
  localparam int NR   = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 4;
  localparam int CW   = 3;

  logic             clk = 1'b0;
  logic             obi_areset;
  logic [NR-1:0]    req_req, req_gnt, req_we, req_r_valid, req_r_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_w_data;
  logic [DW-1:0]    req_r_data;
  logic             obi_master_req, obi_master_gnt, obi_master_we;
  logic [AW-1:0]    obi_master_addr;
  logic [DW-1:0]    obi_master_w_data, obi_master_r_data;
  logic             obi_master_r_valid, obi_master_r_ready;
  logic [CW-1:0]    outstanding;
  logic             spurious_rsp, dbg_state;

  always #5 clk = ~clk;

  obi_master_arbiter #(.NUM_REQ(NR), .OBI_ADDR_WIDTH(AW), .OBI_DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .obi_aclk(clk), .obi_areset(obi_areset),
    .req_req(req_req), .req_gnt(req_gnt), .req_addr(req_addr), .req_we(req_we),
    .req_w_data(req_w_data), .req_r_valid(req_r_valid), .req_r_ready(req_r_ready),
    .req_r_data(req_r_data), .obi_master_req(obi_master_req), .obi_master_gnt(obi_master_gnt),
    .obi_master_addr(obi_master_addr), .obi_master_we(obi_master_we),
    .obi_master_w_data(obi_master_w_data), .obi_master_r_valid(obi_master_r_valid),
    .obi_master_r_ready(obi_master_r_ready), .obi_master_r_data(obi_master_r_data),
    .outstanding(outstanding), .spurious_rsp(spurious_rsp), .dbg_state_o(dbg_state)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NR-1:0] onehot(input int i);
    onehot = '0;
    onehot[i] = 1'b1;
  endfunction

  // Arbitration rule: first active requester at or after the pointer (or lowest index in fixed mode).
  function automatic int pick(input logic [NR-1:0] r, input int ptr);
    pick = 0;
`ifdef OBI_ARB_FIXED_PRIO_EN
    for (int i = NR - 1; i >= 0; i--) if (r[i]) pick = i;
`else
    for (int k = NR - 1; k >= 0; k--) if (r[(ptr + k) % NR]) pick = (ptr + k) % NR;
`endif
  endfunction

  // Model: ids of granted transactions in order, the pointer, and the locked requester (-1 if none).
  int  exp_q[$];
  int  m_rr   = 0;
  int  m_lock = -1;
  bit  m_spur = 1'b0;
  bit  run    = 1'b0;

  always @(negedge clk) begin : cmp
    int id;
    bit mreq, full, rdy;
    logic [NR-1:0] eg, erv;
    if (run) begin
      full = (exp_q.size() == MAXO);
      id   = 0;
      mreq = 1'b0;
      if (m_lock >= 0) begin
        id   = m_lock;
        mreq = req_req[id];
      end else if (!full && req_req != '0) begin
        id   = pick(req_req, m_rr);
        mreq = 1'b1;
      end
      eg = (mreq && obi_master_gnt) ? onehot(id) : '0;
      chk("m_master_req", {63'd0, obi_master_req}, {63'd0, mreq});
      chk("m_req_gnt", {62'd0, req_gnt}, {62'd0, eg});
      if (mreq) begin
        chk("m_addr", {32'd0, obi_master_addr}, {32'd0, req_addr[id*AW +: AW]});
        chk("m_we", {63'd0, obi_master_we}, {63'd0, req_we[id]});
        chk("m_wdata", {32'd0, obi_master_w_data}, {32'd0, req_w_data[id*DW +: DW]});
      end
      if (exp_q.size() > 0) begin
        erv = obi_master_r_valid ? onehot(exp_q[0]) : '0;
        rdy = req_r_ready[exp_q[0]];
      end else begin
        erv = '0;
        rdy = 1'b1;
      end
      chk("m_r_valid", {62'd0, req_r_valid}, {62'd0, erv});
      chk("m_r_ready", {63'd0, obi_master_r_ready}, {63'd0, rdy});
      if (erv != '0) chk("m_r_data", {32'd0, req_r_data}, {32'd0, obi_master_r_data});
      chk("m_outstanding", {61'd0, outstanding}, 64'(exp_q.size()));
      chk("m_spurious", {63'd0, spurious_rsp}, {63'd0, m_spur});
      if (obi_areset) begin
        exp_q.delete();
        m_rr   = 0;
        m_lock = -1;
        m_spur = 1'b0;
      end else begin
        if (obi_master_r_valid) begin
          if (exp_q.size() == 0) m_spur = 1'b1;
          else if (rdy) void'(exp_q.pop_front());
        end
        if (mreq && obi_master_gnt) begin
          exp_q.push_back(id);
          m_rr   = (id + 1) % NR;
          m_lock = -1;
        end else if (m_lock >= 0) begin
          if (!req_req[m_lock]) m_lock = -1;
        end else if (mreq) begin
          m_lock = id;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  bit fixed_mode;

  initial begin
`ifdef OBI_ARB_FIXED_PRIO_EN
    fixed_mode = 1'b1;
`else
    fixed_mode = 1'b0;
`endif
    obi_areset = 1'b1;
    req_req = '0; req_we = 2'b10; req_r_ready = '1;
    req_addr = {32'h2000, 32'h1000};
    req_w_data = {32'hBBBB_0001, 32'hAAAA_0000};
    obi_master_gnt = 1'b0; obi_master_r_valid = 1'b0; obi_master_r_data = '0;

    // Reset state
    step();
    run = 1'b1;
    at_neg();
    chk("rst_outstanding", {61'd0, outstanding}, 64'd0);
    chk("rst_master_req", {63'd0, obi_master_req}, 64'd0);
    chk("rst_gnt", {62'd0, req_gnt}, 64'd0);
    chk("rst_r_valid", {62'd0, req_r_valid}, 64'd0);
    chk("rst_r_ready", {63'd0, obi_master_r_ready}, 64'd1);
    chk("rst_spurious", {63'd0, spurious_rsp}, 64'd0);
    step();
    obi_areset = 1'b0;

    // Round-robin with gnt held until the FIFO saturates
    req_req = 2'b11; obi_master_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      if (fixed_mode || i % 2 == 0) begin
        chk("rr_gnt", {62'd0, req_gnt}, 64'h1);
        chk("rr_addr", {32'd0, obi_master_addr}, 64'h1000);
      end else begin
        chk("rr_gnt", {62'd0, req_gnt}, 64'h2);
        chk("rr_addr", {32'd0, obi_master_addr}, 64'h2000);
      end
      step();
    end
    at_neg();
    chk("rr_full_outstanding", {61'd0, outstanding}, 64'd4);
    chk("rr_full_req", {63'd0, obi_master_req}, 64'd0);
    step();
    req_req = '0; obi_master_gnt = 1'b0; obi_master_r_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      obi_master_r_data = 32'h100 + 32'(i);
      at_neg();
      chk("rr_rsp_route", {62'd0, req_r_valid}, (fixed_mode || i % 2 == 0) ? 64'h1 : 64'h2);
      chk("rr_rsp_data", {32'd0, req_r_data}, 64'h100 + 64'(i));
      step();
    end
    obi_master_r_valid = 1'b0;
    at_neg();
    chk("rr_drained", {61'd0, outstanding}, 64'd0);

    // Lock stability while another requester joins
    step();
    req_addr = {32'h2000, 32'h10}; req_req = 2'b01;
    at_neg();
    step();
    req_req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("lock_addr", {32'd0, obi_master_addr}, 64'h10);
      chk("lock_gnt", {62'd0, req_gnt}, 64'd0);
      chk("lock_state", {63'd0, dbg_state}, 64'd1);
      step();
    end
    obi_master_gnt = 1'b1;
    at_neg();
    chk("lock_granted", {62'd0, req_gnt}, 64'h1);
    step();
    at_neg();
    chk("lock_next", {62'd0, req_gnt}, fixed_mode ? 64'h1 : 64'h2);
    step();
    req_req = '0; obi_master_gnt = 1'b0; obi_master_r_valid = 1'b1;
    at_neg(); step();
    at_neg(); step();
    obi_master_r_valid = 1'b0;

    // Backpressure: full FIFO stalls requests until a response frees a slot
    req_addr = {32'h2000, 32'h40}; req_req = 2'b01; obi_master_gnt = 1'b1;
    repeat (4) begin at_neg(); step(); end
    at_neg();
    chk("bp_outstanding", {61'd0, outstanding}, 64'd4);
    chk("bp_req_low", {63'd0, obi_master_req}, 64'd0);
    chk("bp_no_gnt", {62'd0, req_gnt}, 64'd0);
    step();
    obi_master_r_valid = 1'b1; obi_master_r_data = 32'h55;
    at_neg();
    chk("bp_rsp", {62'd0, req_r_valid}, 64'h1);
    step();
    obi_master_r_valid = 1'b0;
    at_neg();
    chk("bp_after_pop", {61'd0, outstanding}, 64'd3);
    chk("bp_resume", {62'd0, req_gnt}, 64'h1);
    step();
    req_req = '0; obi_master_gnt = 1'b0; obi_master_r_valid = 1'b1;
    repeat (4) begin at_neg(); step(); end
    obi_master_r_valid = 1'b0;
    at_neg();
    chk("bp_drained", {61'd0, outstanding}, 64'd0);

    // Response routing for grant order 1,0,1
    step();
    req_req = 2'b10; obi_master_gnt = 1'b1;
    at_neg(); chk("route_g1", {62'd0, req_gnt}, 64'h2); step();
    req_req = 2'b01;
    at_neg(); chk("route_g0", {62'd0, req_gnt}, 64'h1); step();
    req_req = 2'b10;
    at_neg(); chk("route_g1b", {62'd0, req_gnt}, 64'h2); step();
    req_req = '0; obi_master_gnt = 1'b0; obi_master_r_valid = 1'b1; obi_master_r_data = 32'hA;
    at_neg();
    chk("route_a", {62'd0, req_r_valid}, 64'h2);
    chk("route_a_data", {32'd0, req_r_data}, 64'hA);
    step();
    obi_master_r_data = 32'hB;
    at_neg(); chk("route_b", {62'd0, req_r_valid}, 64'h1); step();
    obi_master_r_data = 32'hC; req_r_ready = 2'b01;
    at_neg();
    chk("route_c", {62'd0, req_r_valid}, 64'h2);
    chk("route_c_stall", {63'd0, obi_master_r_ready}, 64'd0);
    step();
    at_neg();
    chk("route_c_held", {61'd0, outstanding}, 64'd1);
    step();
    req_r_ready = 2'b11;
    at_neg(); chk("route_c_go", {63'd0, obi_master_r_ready}, 64'd1); step();
    obi_master_r_valid = 1'b0;
    at_neg();
    chk("route_done", {61'd0, outstanding}, 64'd0);

    // Request dropped while locked
    step();
    req_req = 2'b01; obi_master_gnt = 1'b0;
    at_neg(); step();
    req_req = '0;
    at_neg();
    chk("drop_req_low", {63'd0, obi_master_req}, 64'd0);
    step();
    at_neg();
    chk("drop_idle", {63'd0, dbg_state}, 64'd0);

    // Reset mid-flight, then a late response
    step();
    req_req = 2'b11; obi_master_gnt = 1'b1;
    at_neg(); step();
    at_neg(); step();
    req_req = '0; obi_master_gnt = 1'b0;
    at_neg();
    chk("sp_outstanding", {61'd0, outstanding}, 64'd2);
    step();
    obi_areset = 1'b1;
    at_neg(); step();
    obi_areset = 1'b0; obi_master_r_valid = 1'b1; obi_master_r_data = 32'hDEAD;
    at_neg();
    chk("sp_no_fwd", {62'd0, req_r_valid}, 64'd0);
    chk("sp_ready", {63'd0, obi_master_r_ready}, 64'd1);
    step();
    obi_master_r_valid = 1'b0;
    at_neg();
    chk("sp_flag", {63'd0, spurious_rsp}, 64'd1);
    chk("sp_zero", {61'd0, outstanding}, 64'd0);
    step();

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
